// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host receiver: input conditioning, 11-bit frame checking and
// scan-code prefix handling, producing a toggle-qualified 11-bit key event word.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err_parity,
  output logic        err_frame
);

  localparam int FL_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d;
  logic [FL_W-1:0] fcnt_q, fcnt_d;
  logic            fall;

  logic [1:0]      state_q, state_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic            bvld_q, bvld_d;
  logic            errp_q, errp_d;
  logic            errf_q, errf_d;

  logic [10:0]     key_q, key_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [2:0]      skip_q, skip_d;

  // Glitch filter: the synchronized clock must disagree with the filtered level
  // for FILTER_LEN consecutive samples before the filtered level follows it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    fall   = 1'b0;
    if (clk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FL_W'(FILTER_LEN - 1)) begin
      filt_d = clk_s2_q;
      fcnt_d = '0;
      fall   = filt_q;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    to_d    = '0;
    sh_d    = sh_q;
    par_d   = par_q;
    bvld_d  = 1'b0;
    errp_d  = 1'b0;
    errf_d  = 1'b0;
    if (state_q != S_IDLE && !fall) begin
      if (to_q == TO_W'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        errf_d  = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end else begin
            errf_d = 1'b1;
          end
        end
        S_DATA: begin
          sh_d   = {dat_s2_q, sh_q[7:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (!dat_s2_q)                errf_d = 1'b1;
          else if (!(^{sh_q, par_q}))   errp_d = 1'b1;
          else                          bvld_d = 1'b1;
        end
      endcase
    end
  end

  // Byte layer: sh_q still holds the accepted byte on the cycle after bvld_q is set.
  always_comb begin
    key_d  = key_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    if (bvld_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 1'b1;
        if (skip_q == 3'd1) begin
          key_d = {~key_q[10], 1'b1, 1'b1, 8'h77};
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end else begin
        case (sh_q)
          8'hE0: ext_d  = 1'b1;
          8'hF0: brk_d  = 1'b1;
          8'hE1: skip_d = 3'd7;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
          default: begin
            key_d = {~key_q[10], ~brk_q, ext_q, sh_q};
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      to_q     <= '0;
      bvld_q   <= 1'b0;
      errp_q   <= 1'b0;
      errf_q   <= 1'b0;
      key_q    <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      to_q     <= to_d;
      bvld_q   <= bvld_d;
      errp_q   <= errp_d;
      errf_q   <= errf_d;
      key_q    <= key_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    sh_q  <= sh_d;
    par_q <= par_d;
  end

  assign ps2_key    = key_q;
  assign err_parity = errp_q;
  assign err_frame  = errf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames at a scaled bit rate
// and checks key events, event counts and error pulses against hand-computed values.
module tb_ps2_key_decoder;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HB   = 40;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        err_parity;
  logic        err_frame;

  int vectors = 0;
  int miscompares = 0;
  int ev_cnt = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ev0, pe0, fe0;
  logic [10:0] key_prev = '0;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_key    (ps2_key),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (ps2_key != key_prev) ev_cnt++;
    key_prev = ps2_key;
    if (err_parity) perr_cnt++;
    if (err_frame)  ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] c, input bit pflip, input bit stop);
    return {stop, (~^c) ^ pflip, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = b[i];
      if (glitch) begin
        idle(10); ps2_clk = 1'b0; idle(4); ps2_clk = 1'b1; idle(HB - 14);
      end else begin
        idle(HB);
      end
      ps2_clk = 1'b0;
      idle(HB);
      ps2_clk = 1'b1;
    end
    idle(HB);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] c);
    send_bits(mk(c, 1'b0, 1'b1), 11, 1'b0);
    idle(60);
  endtask

  task automatic mark;
    @(negedge clk_sys);
    ev0 = ev_cnt; pe0 = perr_cnt; fe0 = ferr_cnt;
  endtask

  initial begin
    idle(5);
    @(negedge clk_sys);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_errs", {30'd0, err_parity, err_frame}, 32'd0);
    reset = 1'b0;
    idle(20);

    mark();
    send(8'h1C);
    @(negedge clk_sys);
    check("make_1C", 32'(ps2_key), 32'h61C);
    check("make_1C_events", ev_cnt - ev0, 1);
    check("make_1C_errs", (perr_cnt - pe0) + (ferr_cnt - fe0), 0);

    mark();
    send(8'hF0);
    @(negedge clk_sys);
    check("F0_no_event", ev_cnt - ev0, 0);
    send(8'h1C);
    @(negedge clk_sys);
    check("break_1C", 32'(ps2_key), 32'h01C);
    check("break_1C_events", ev_cnt - ev0, 1);

    send(8'hE0); send(8'h75);
    @(negedge clk_sys);
    check("ext_make_75", 32'(ps2_key), 32'h775);
    send(8'hE0); send(8'hF0); send(8'h75);
    @(negedge clk_sys);
    check("ext_break_75", 32'(ps2_key), 32'h175);
    send(8'h29);
    @(negedge clk_sys);
    check("ext_cleared_29", 32'(ps2_key), 32'h629);

    mark();
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11, 1'b0);
    idle(60);
    @(negedge clk_sys);
    check("parity_pulse", perr_cnt - pe0, 1);
    check("parity_no_frame", ferr_cnt - fe0, 0);
    check("parity_key_hold", 32'(ps2_key), 32'h629);

    mark();
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11, 1'b0);
    idle(60);
    @(negedge clk_sys);
    check("stop_frame_pulse", ferr_cnt - fe0, 1);
    check("stop_no_parity", perr_cnt - pe0, 0);
    check("stop_key_hold", 32'(ps2_key), 32'h629);

    mark();
    send_bits(mk(8'h29, 1'b0, 1'b1), 5, 1'b0);
    idle(TO + 50);
    @(negedge clk_sys);
    check("timeout_pulse", ferr_cnt - fe0, 1);
    check("timeout_key_hold", 32'(ps2_key), 32'h629);
    send(8'h29);
    @(negedge clk_sys);
    check("after_timeout_29", 32'(ps2_key), 32'h229);
    check("after_timeout_errs", ferr_cnt - fe0, 1);

    send(8'hE0);
    send_bits(mk(8'h75, 1'b0, 1'b0), 11, 1'b0);
    idle(60);
    send(8'h75);
    @(negedge clk_sys);
    check("prefix_kept_75", 32'(ps2_key), 32'h775);

    mark();
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0; idle(5); ps2_clk = 1'b1; idle(20);
    end
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11, 1'b1);
    idle(60);
    @(negedge clk_sys);
    check("glitch_1C", 32'(ps2_key), 32'h21C);
    check("glitch_no_errs", (ferr_cnt - fe0) + (perr_cnt - pe0), 0);

    send_bits(mk(8'h29, 1'b0, 1'b1), 5, 1'b0);
    @(posedge clk_sys);
    #3 reset = 1'b1;
    #1;
    check("async_reset_key", 32'(ps2_key), 32'h000);
    check("async_reset_errs", {30'd0, err_parity, err_frame}, 32'd0);
    idle(3);
    reset = 1'b0;
    idle(20);

    mark();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    @(negedge clk_sys);
    check("pause_pending", ev_cnt - ev0, 0);
    send(8'h77);
    @(negedge clk_sys);
    check("pause_key", 32'(ps2_key), 32'h777);
    check("pause_events", ev_cnt - ev0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
